// File: rtl/axis_fifo_rr_arbiter.sv
// axis_fifo_rr_arbiter
//
// Merges NUM_CH strobe-interface FIFOs onto one AXI-Stream master port.
// Arbitration is round-robin at packet granularity: once a channel is granted,
// it keeps the grant until the beat with its last flag is accepted downstream.
// The output is a single registered beat buffer that is refilled in the same
// cycle it drains, so a granted FIFO can stream at one beat per clock.
//
// Ports:
//   clk, rst           clock and synchronous active-high reset
//   i_ch_enable        per-channel arbitration enable (sampled only in IDLE)
//   i_fifo_not_empty   per-FIFO not-empty flag
//   i_fifo_r_data      packed FIFO head words, channel k in slice k;
//                      bit DATA_WIDTH of each word is the last flag
//   o_fifo_r_stb       per-FIFO pop strobe, combinational, one-hot or zero
//   o_axis_*           AXI-Stream master; tuser carries the source channel
//   o_busy             high while a packet is being streamed
//   o_pkt_count        number of completed packets, wraps
module axis_fifo_rr_arbiter #(
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 16,
    localparam int unsigned USER_WIDTH = $clog2(NUM_CH),
    localparam int unsigned WORD_WIDTH = DATA_WIDTH + 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_CH-1:0]            i_ch_enable,
    input  logic [NUM_CH-1:0]            i_fifo_not_empty,
    input  logic [NUM_CH*WORD_WIDTH-1:0] i_fifo_r_data,
    output logic [NUM_CH-1:0]            o_fifo_r_stb,
    output logic                         o_axis_tvalid,
    input  logic                         i_axis_tready,
    output logic [DATA_WIDTH-1:0]        o_axis_tdata,
    output logic                         o_axis_tlast,
    output logic [USER_WIDTH-1:0]        o_axis_tuser,
    output logic                         o_busy,
    output logic [CNT_WIDTH-1:0]         o_pkt_count
);

    typedef enum logic [0:0] {StIdle, StStream} state_e;

    state_e                  state_q, state_d;
    logic [USER_WIDTH-1:0]   grant_q, grant_d;
    logic [USER_WIDTH-1:0]   last_grant_q, last_grant_d;
    logic                    tvalid_q, tvalid_d;
    logic [DATA_WIDTH-1:0]   tdata_q, tdata_d;
    logic                    tlast_q, tlast_d;
    logic [USER_WIDTH-1:0]   tuser_q, tuser_d;
    logic                    eop_loaded_q, eop_loaded_d;
    logic [CNT_WIDTH-1:0]    pkt_count_q, pkt_count_d;

    logic [NUM_CH-1:0]       req;
    logic [WORD_WIDTH-1:0]   words [NUM_CH];
    logic [WORD_WIDTH-1:0]   head;
    logic                    rr_found;
    logic [USER_WIDTH-1:0]   rr_next;
    logic                    pop;
    logic                    accept;

    assign req = i_ch_enable & i_fifo_not_empty;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_words
        assign words[k] = i_fifo_r_data[k*WORD_WIDTH +: WORD_WIDTH];
    end

    assign head = words[grant_q];

    // Round-robin search starting one past the previous grant, with wrap.
    always_comb begin
        logic [USER_WIDTH-1:0] idx;
        rr_found = 1'b0;
        rr_next  = '0;
        idx      = '0;
        for (int unsigned i = 1; i <= NUM_CH; i++) begin
            idx = USER_WIDTH'((32'(last_grant_q) + i) % NUM_CH);
            if (!rr_found && req[idx]) begin
                rr_found = 1'b1;
                rr_next  = idx;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        tvalid_d     = tvalid_q;
        tdata_d      = tdata_q;
        tlast_d      = tlast_q;
        tuser_d      = tuser_q;
        eop_loaded_d = eop_loaded_q;
        pkt_count_d  = pkt_count_q;
        pop          = 1'b0;
        accept       = 1'b0;
        o_fifo_r_stb = '0;

        unique case (state_q)
            StIdle: begin
                if (rr_found) begin
                    grant_d      = rr_next;
                    last_grant_d = rr_next;
                    state_d      = StStream;
                end
            end
            StStream: begin
                // Pop only into an empty buffer or one draining this cycle, and
                // never past the end of the current packet.
                pop    = i_fifo_not_empty[grant_q] & ~eop_loaded_q &
                         (~tvalid_q | i_axis_tready) & ~rst;
                accept = tvalid_q & i_axis_tready;
                if (pop) begin
                    tvalid_d = 1'b1;
                    tdata_d  = head[DATA_WIDTH-1:0];
                    tlast_d  = head[DATA_WIDTH];
                    tuser_d  = grant_q;
                    if (head[DATA_WIDTH]) begin
                        eop_loaded_d = 1'b1;
                    end
                end else if (accept) begin
                    tvalid_d = 1'b0;
                end
                // A buffered last beat implies eop_loaded, so no pop coincides.
                if (accept && tlast_q) begin
                    eop_loaded_d = 1'b0;
                    pkt_count_d  = pkt_count_q + 1'b1;
                    state_d      = StIdle;
                end
                o_fifo_r_stb[grant_q] = pop;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            grant_q      <= '0;
            last_grant_q <= USER_WIDTH'(NUM_CH - 1);
            tvalid_q     <= 1'b0;
            tdata_q      <= '0;
            tlast_q      <= 1'b0;
            tuser_q      <= '0;
            eop_loaded_q <= 1'b0;
            pkt_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            tvalid_q     <= tvalid_d;
            tdata_q      <= tdata_d;
            tlast_q      <= tlast_d;
            tuser_q      <= tuser_d;
            eop_loaded_q <= eop_loaded_d;
            pkt_count_q  <= pkt_count_d;
        end
    end

    assign o_axis_tvalid = tvalid_q;
    assign o_axis_tdata  = tdata_q;
    assign o_axis_tlast  = tlast_q;
    assign o_axis_tuser  = tuser_q;
    assign o_busy        = (state_q == StStream);
    assign o_pkt_count   = pkt_count_q;

endmodule
